// File: rtl/demux_1x3_reg.sv
// demux_1x3_reg: registered 1-to-3 demultiplexer with addressed or auto-sequenced fill, valid tracking and sticky error
module demux_1x3_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         load,
  input  logic         mode,
  input  logic [1:0]   ctrl,
  input  logic         clr,
  input  logic [W-1:0] D,
  output logic [W-1:0] S0,
  output logic [W-1:0] S1,
  output logic [W-1:0] S2,
  output logic         V0,
  output logic         V1,
  output logic         V2,
  output logic [1:0]   ptr,
  output logic         done,
  output logic         err
);
  typedef enum logic [1:0] {IDLE, FILL, FULL} state_t;
  state_t state, state_n;
  logic [2:0] v, v_n, hit;
  logic [1:0] ptr_n, sel;
  logic err_n, act_clr, wr;
  // next state and next register values; start beats clr beats load
  always_comb begin
    act_clr = !start && clr && state != IDLE;
    sel = mode ? ptr : ctrl;
    wr = !start && !clr && load && state == FILL && sel != 2'd3;
    hit = wr ? 3'b001 << sel : 3'b000;
    v_n = (start || act_clr) ? 3'b000 : v | hit;
    ptr_n = (start || act_clr) ? 2'd0 : (wr && mode) ? (ptr == 2'd2 ? 2'd0 : ptr + 2'd1) : ptr;
    err_n = start ? 1'b0 : (!clr && load && (state == FULL || (state == FILL && sel == 2'd3))) ? 1'b1 : err;
    state_n = start ? FILL : act_clr ? IDLE : (state == FILL && v_n == 3'b111) ? FULL : state;
  end
  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else state <= state_n;
  end
  // data, valid, pointer and error registers; data words survive start and clr
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      S0 <= '0;
      S1 <= '0;
      S2 <= '0;
      v <= 3'b000;
      ptr <= 2'd0;
      err <= 1'b0;
    end else begin
      v <= v_n;
      ptr <= ptr_n;
      err <= err_n;
      if (hit[0]) S0 <= D;
      if (hit[1]) S1 <= D;
      if (hit[2]) S2 <= D;
    end
  end
  assign {V2, V1, V0} = v;
  assign done = state == FULL;
endmodule

// File: doc/demux_1x3_reg.md
DEMUX_1X3_REG -- requirements
Module: demux_1x3_reg

Interface
REQ-001 Parameter: W, default 8, data word width.
REQ-002 clk  input  1  rising-edge clock; all state changes on this edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  begin a fill cycle.
REQ-005 load  input  1  write D to the selected output register this cycle.
REQ-006 mode  input  1  0 = address by ctrl; 1 = auto-sequence by internal pointer.
REQ-007 ctrl  input  2  target select in mode 0: 00->S0, 01->S1, 10->S2, 11 invalid.
REQ-008 clr  input  1  consume; release the FULL condition.
REQ-009 D  input  W  data word.
REQ-010 S0, S1, S2  output  W each  registered demultiplexed words.
REQ-011 V0, V1, V2  output  1 each  per-register valid flags.
REQ-012 ptr  output  2  auto-sequence pointer, range 0..2.
REQ-013 done  output  1  high while all three registers hold valid data (FULL).
REQ-014 err  output  1  sticky error flag.

Function
REQ-015 State machine SHALL have states IDLE, FILL, FULL; done = (state == FULL), registered.
REQ-016 start, in any state: next state FILL; V0..V2 <= 0; ptr <= 0; err <= 0; S0..S2 retain their values.
REQ-017 Priority SHALL be start > clr > load; a lower-priority request in the same cycle is discarded with no side effect.
REQ-018 load in IDLE: ignored; no register write, err unchanged.
REQ-019 load in FILL, mode 0, ctrl in {00, 01, 10}: Sctrl <= D and Vctrl <= 1 on the same edge; ptr unchanged.
REQ-020 load in FILL, mode 0, ctrl = 11: no write; err <= 1.
REQ-021 load in FILL, mode 1: Sptr <= D; Vptr <= 1; ptr <= ptr+1, wrapping 2->0.
REQ-022 Writing an already-valid register in FILL: overwrite permitted; V stays 1; no error.
REQ-023 Write latency: S and V reflect the write one clock edge after load is sampled; done rises on the same edge as the write that makes V0..V2 = 111.
REQ-024 load in FULL: ignored, no overwrite; err <= 1 (overflow).
REQ-025 clr in FILL or FULL: next state IDLE; V0..V2 <= 0; ptr <= 0; S0..S2 and err retain their values.
REQ-026 clr in IDLE: no effect.
REQ-027 err SHALL clear only on start or rst.
REQ-028 ptr SHALL never take the value 3.

Reset
REQ-029 While rst = 1, immediately and independently of clk: state IDLE; S0..S2 = 0; V0..V2 = 0; ptr = 0; done = 0; err = 0.
REQ-030 rst asserted mid-fill SHALL discard all partial fill state; after rst deasserts, the block waits in IDLE for start.

Verification
REQ-031 Auto fill: rst; start; mode = 1; load D = 0x11, 0x22, 0x33 on consecutive cycles -> S0/S1/S2 = 11/22/33, V = 111, done = 1 after the third edge, ptr = 0.
REQ-032 Addressed fill: start; mode = 0; load ctrl = 10 D = 0xA0, then 00 D = 0xB0, then 10 D = 0xC0, then 01 D = 0xD0 -> S2 = C0 (overwrite), S0 = B0, S1 = D0; done rises only on the fourth load.
REQ-033 Errors: in FILL, load with ctrl = 11 -> err = 1, V unchanged; in FULL, load D = 0xFF -> S unchanged, err = 1; err remains 1 until the next start.
REQ-034 Priority: start and load asserted together in FULL -> state FILL, V = 000, no write; clr and load together in FILL -> state IDLE, no write.
REQ-035 Async reset: assert rst between clock edges with V = 011 -> all outputs go to 0 before the next edge; load in IDLE after reset has no effect.
